// File: rtl/reg_readback_tx.sv
// Parameter-memory read-back framer: fetches a requested address range byte by byte
// and presents SYNC, addr, len, data..., checksum to the UART transmitter.
module reg_readback_tx #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_SYNC = 3'd1,
        SEND_ADDR = 3'd2,
        SEND_LEN  = 3'd3,
        FETCH     = 3'd4,
        WAIT_RD   = 3'd5,
        SEND_DATA = 3'd6,
        SEND_CSUM = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [7:0]        rem_q, rem_d;
    logic [7:0]        csum_q, csum_d;
    logic              xfer_s;

    // Next-state and next-output logic; every output is registered from its _d value.
    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        busy_d      = busy_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        addr_cnt_d  = addr_cnt_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        xfer_s      = tx_valid_q & tx_ready;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d    = SEND_SYNC;
                    busy_d     = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                    addr_cnt_d = req_addr;
                    rem_d      = req_len;
                    csum_d     = 8'h00;
                end else begin
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    tx_valid_d  = 1'b0;
                end
            end
            SEND_SYNC: begin
                if (xfer_s) begin
                    state_d   = SEND_ADDR;
                    tx_data_d = 8'(addr_cnt_q);
                    csum_d    = csum_q + 8'(addr_cnt_q);
                end else begin
                    state_d = state_q;
                end
            end
            SEND_ADDR: begin
                if (xfer_s) begin
                    state_d   = SEND_LEN;
                    tx_data_d = rem_q;
                    csum_d    = csum_q + rem_q;
                end else begin
                    state_d = state_q;
                end
            end
            SEND_LEN, SEND_DATA: begin
                // rem_q already counts down the byte just offered, so zero means no fetch left
                if (xfer_s) begin
                    if (rem_q == 8'd0) begin
                        state_d   = SEND_CSUM;
                        tx_data_d = csum_q;
                    end else begin
                        state_d     = FETCH;
                        tx_valid_d  = 1'b0;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = addr_cnt_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            FETCH: begin
                state_d    = WAIT_RD;
                addr_cnt_d = addr_cnt_q + ADDR_W'(1);
            end
            WAIT_RD: begin
                state_d    = SEND_DATA;
                tx_valid_d = 1'b1;
                tx_data_d  = mem_rd_data;
                csum_d     = csum_q + mem_rd_data;
                rem_d      = rem_q - 8'd1;
            end
            SEND_CSUM: begin
                if (xfer_s) begin
                    state_d     = IDLE;
                    tx_valid_d  = 1'b0;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            addr_cnt_q  <= '0;
            rem_q       <= 8'h00;
            csum_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            addr_cnt_q  <= addr_cnt_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_reg_readback_tx.sv
// Scoreboard bench for reg_readback_tx: directed frames with hand-computed bytes,
// a memory responder, and a negedge monitor that pops and compares transferred bytes.
module tb_reg_readback_tx;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_len = 8'h00;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       busy;

    reg_readback_tx #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk_in(clk_in), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] mem [0:255];
    logic [7:0] exp_q [$];
    logic [7:0] rd_log [$];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int rdy_mode = 0;   // 0 ready high, 1 toggle, 2 held low, 3 manual
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    logic [7:0] frame1 [0:6];
    logic [7:0] frame2 [0:3];
    logic [7:0] frame3 [0:6];

    // Memory read port: data appears the cycle after the strobe.
    always @(posedge clk_in) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Monitor: transfers, stall stability, read strobes, request acceptances.
    always @(negedge clk_in) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(tx_valid === 1'b1 && tx_data === stall_data)) begin
                    errors++;
                    $display("FAIL stall_hold: got tx_valid=%0b tx_data=%02h, want tx_valid=1 tx_data=%02h",
                             tx_valid, tx_data, stall_data);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h, want no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, want %02h", tx_data, e);
                    end
                end
            end
            stall_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0);
            stall_data = tx_data;
            if (mem_rd_en === 1'b1) begin
                rd_cnt++;
                rd_log.push_back(mem_addr);
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) acc_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            2: tx_ready = 1'b0;
            default: ;
        endcase
    endtask

    task automatic do_req(input logic [7:0] a, input logic [7:0] l, input bit hold);
        int n;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        n = 0;
        while (req_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("req_wait_timeout", 32'(n >= 300), 32'd0);
        tick();
        chk("sync_latency", {22'd0, tx_valid, busy, tx_data}, {22'd0, 1'b1, 1'b1, 8'hA5});
        chk("req_ready_drop", 32'(req_ready), 32'd0);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 600) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(n >= 600), 32'd0);
        chk({name, "_idle"}, {30'd0, busy, req_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    task automatic wait_offer(input logic [7:0] b);
        int n;
        n = 0;
        while (!(tx_valid === 1'b1 && tx_data === b) && n < 300) begin
            tick();
            n++;
        end
        chk("offer_timeout", 32'(n >= 300), 32'd0);
    endtask

    initial begin
        int acc0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03;
        mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC;
        frame1 = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
        frame2 = '{8'hA5, 8'h20, 8'h00, 8'h20};
        // FE+03+AA+BB+CC = 0x332, low byte 0x32
        frame3 = '{8'hA5, 8'hFE, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h32};

        // Reset values
        rdy_mode = 3;
        tick(); tick();
        chk("reset_outputs", {12'd0, req_ready, mem_rd_en, mem_addr, tx_valid, tx_data, busy},
            {12'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
        reset = 1'b0;
        tick();
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);

        // Case 1: basic three-byte read
        rdy_mode = 0; rd_cnt = 0; rd_log.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(frame1[i]);
        do_req(8'h10, 8'd3, 1'b0);
        wait_done("case1");
        chk("case1_reads", 32'(rd_cnt), 32'd3);

        // Case 2: zero-length read
        rd_cnt = 0; rd_log.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(frame2[i]);
        do_req(8'h20, 8'd0, 1'b0);
        wait_done("case2");
        chk("case2_reads", 32'(rd_cnt), 32'd0);

        // Case 3: address wrap
        rd_cnt = 0; rd_log.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(frame3[i]);
        do_req(8'hFE, 8'd3, 1'b0);
        wait_done("case3");
        chk("case3_reads", 32'(rd_cnt), 32'd3);
        if (rd_log.size() == 3)
            chk("case3_addr_seq", {8'd0, rd_log[0], rd_log[1], rd_log[2]}, {8'd0, 8'hFE, 8'hFF, 8'h00});
        else
            chk("case3_addr_count", 32'(rd_log.size()), 32'd3);

        // Case 4: toggling backpressure plus a long stall mid-data
        rdy_mode = 1; rd_cnt = 0;
        for (int i = 0; i < 7; i++) exp_q.push_back(frame1[i]);
        do_req(8'h10, 8'd3, 1'b0);
        wait_offer(8'h01);
        rdy_mode = 2;
        repeat (10) tick();
        rdy_mode = 1;
        wait_done("case4");
        chk("case4_reads", 32'(rd_cnt), 32'd3);

        // Case 5: reset while data byte 02 is offered
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(frame1[i]);
        do_req(8'h10, 8'd3, 1'b0);
        wait_offer(8'h02);
        rdy_mode = 3;
        tx_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("case5_abort", {29'd0, tx_valid, busy, req_ready}, {29'd0, 1'b0, 1'b0, 1'b0});
        chk("case5_sent_before_abort", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        tick();
        chk("case5_req_ready", 32'(req_ready), 32'd1);
        rdy_mode = 0;
        for (int i = 0; i < 7; i++) exp_q.push_back(frame1[i]);
        do_req(8'h10, 8'd3, 1'b0);
        wait_done("case5");

        // Case 6: request held through an active frame is taken once, at IDLE
        acc0 = acc_cnt;
        for (int i = 0; i < 7; i++) exp_q.push_back(frame1[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(frame2[i]);
        do_req(8'h10, 8'd3, 1'b1);
        req_addr = 8'h20;
        req_len  = 8'd0;
        do_req(8'h20, 8'd0, 1'b0);
        wait_done("case6");
        repeat (5) tick();
        chk("case6_accepts", 32'(acc_cnt - acc0), 32'd2);
        chk("case6_quiet", {31'd0, tx_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
